// File: rtl/program_sequencer_pkg.sv
// Shared types and opcode constants for the program sequencer and its bench.
package program_sequencer_pkg;

  localparam int DW_DEF      = 16;
  localparam int OPC_LSB_DEF = 6;

  // Core opcode field values (word[OPC_LSB+2:OPC_LSB]).
  localparam logic [2:0] OPC_MV  = 3'b000;
  localparam logic [2:0] OPC_MVI = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b011;

  localparam logic [2:0] MVI_OPC_DEF = OPC_MVI;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_FIN,
    S_ERR
  } state_t;

endpackage

// File: rtl/program_sequencer_prog_mem.sv
// Program store: 2^AW x DW RAM, synchronous write, asynchronous read, no reset.
module program_sequencer_prog_mem #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Streams a loaded program onto the core's din bus, one run pulse per
// instruction, waiting for done and watching for a stalled core.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int         DW      = DW_DEF,
  parameter int         AW      = 6,
  parameter int         TIMEOUT = 16,
  parameter int         OPC_LSB = OPC_LSB_DEF,
  parameter logic [2:0] MVI_OPC = MVI_OPC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          done,
  output logic [DW-1:0] din,
  output logic          run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          finished,
  output logic          timeout_err
);

  localparam int          WDW   = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic          run_q, run_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
  logic          err_q, err_d;

  logic [AW:0]   len_eff;
  logic [AW:0]   pc_nxt_ext;
  logic          last_word;
  logic          imm_ok;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  function automatic logic is_mvi(input logic [DW-1:0] w);
    return w[OPC_LSB +: 3] == MVI_OPC;
  endfunction

  // Oversized lengths clamp to the memory depth; pc+1 is kept one bit wider
  // so the last address compares as complete instead of wrapping to 0.
  assign len_eff    = (prog_len > DEPTH) ? DEPTH : prog_len;
  assign pc_nxt_ext = {1'b0, pc_q} + {{AW{1'b0}}, 1'b1};
  assign last_word  = pc_nxt_ext >= len_eff;
  assign imm_ok     = (state_q == S_IMM) && !last_word;
  assign rd_addr    = (state_q == S_IMM) ? pc_nxt_ext[AW-1:0] : pc_q;

  program_sequencer_prog_mem #(
    .DW(DW),
    .AW(AW)
  ) u_prog_mem (
    .clk  (clk),
    .we   (wr_en && !busy_q),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wd_d    = wd_q;
    fin_d   = fin_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_FIN, S_ERR: begin
        if (start) begin
          fin_d = 1'b0;
          err_d = 1'b0;
          pc_d  = '0;
          wd_d  = '0;
          if (len_eff == '0) begin
            state_d = S_FIN;
            fin_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = is_mvi(rd_data) ? S_IMM : S_WAIT;
      end
      S_IMM: begin
        if (last_word) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          pc_d    = pc_nxt_ext[AW-1:0];
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // done is checked first so it wins over a simultaneous watchdog expiry.
        if (done) begin
          if (last_word) begin
            state_d = S_FIN;
            fin_d   = 1'b1;
          end else begin
            pc_d    = pc_nxt_ext[AW-1:0];
            state_d = S_ISSUE;
          end
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    run_d  = (state_d == S_ISSUE);
    busy_d = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wd_q    <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
    end
  end

  // In IMM the immediate (pc+1) is already presented; a missing immediate drives 0.
  assign din = ((state_q == S_ISSUE) || (state_q == S_WAIT) || imm_ok) ? rd_data : '0;
  assign pc  = imm_ok ? pc_nxt_ext[AW-1:0] : pc_q;

  assign run         = run_q;
  assign busy        = busy_q;
  assign finished    = fin_q;
  assign timeout_err = err_q;

endmodule
